// File: rtl/ats_eligibility_calc.sv
// Single-stream 802.1Qcr ATS token-bucket eligibility-time calculator (multiply-only datapath).
// Optional pass/discard frame counters are enabled by defining ATS_ELIGIBILITY_STATS_EN.
//
// state  | meaning
// IDLE   | ready for one frame; sample frame info and config on handshake
// CALC   | form sched_elig and bucket_full from the bucket-empty time
// DECIDE | pick eligibility time, pass/discard, update scheduler/group state
// OUTPUT | hold the result beat until downstream accepts it
module ats_eligibility_calc #(
  parameter int TIMESTAMP_WIDTH = 72,
  parameter int FRAME_LEN_WIDTH = 16,
  parameter int RATE_WIDTH      = 32
) (
  input  logic                                       clk,
  input  logic                                       rstn,
`ifdef ATS_ELIGIBILITY_STATS_EN
  input  logic                                       stats_clear,
  output logic [31:0]                                pass_count,
  output logic [31:0]                                discard_count,
`endif
  input  logic [RATE_WIDTH-1:0]                      time_per_byte,
  input  logic [TIMESTAMP_WIDTH-1:0]                 empty_to_full_duration,
  input  logic [TIMESTAMP_WIDTH-1:0]                 max_residence_time,
  input  logic [TIMESTAMP_WIDTH+FRAME_LEN_WIDTH-1:0] s_axis_frame_info_tdata,
  input  logic                                       s_axis_frame_info_tvalid,
  output logic                                       s_axis_frame_info_tready,
  output logic [TIMESTAMP_WIDTH-1:0]                 m_axis_eligibility_timestamp_tdata,
  output logic                                       m_axis_eligibility_timestamp_tuser,
  output logic                                       m_axis_eligibility_timestamp_tvalid,
  input  logic                                       m_axis_eligibility_timestamp_tready
);
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int PW = FRAME_LEN_WIDTH + RATE_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DECIDE, OUTPUT} state_t;

  state_t                     state_q, state_d;
  logic [TW-1:0]              arrival_q;
  logic [FRAME_LEN_WIDTH-1:0] frame_len_q;
  logic [RATE_WIDTH-1:0]      time_per_byte_q;
  logic [TW-1:0]              empty_to_full_q;
  logic [TW-1:0]              max_res_q;
  logic [TW-1:0]              sched_elig_q;
  logic [TW-1:0]              bucket_full_q;
  logic [TW-1:0]              bucket_empty_q;
  logic [TW-1:0]              group_elig_q;
  logic [TW-1:0]              tdata_q;
  logic                       tuser_q;
  logic                       tvalid_q;

  logic                       in_hs;
  logic                       out_hs;
  logic [PW-1:0]              product;
  logic [TW-1:0]              length_recovery;
  logic [TW-1:0]              elig;
  logic [TW-1:0]              limit;
  logic [TW-1:0]              bucket_next;
  logic                       pass;

  // Gate with rstn so the upstream never sees ready while we are held in reset.
  assign s_axis_frame_info_tready = rstn && (state_q == IDLE);
  assign in_hs  = s_axis_frame_info_tvalid && s_axis_frame_info_tready;
  assign out_hs = tvalid_q && m_axis_eligibility_timestamp_tready;

  assign product         = PW'(frame_len_q) * PW'(time_per_byte_q);
  assign length_recovery = TW'(product);

  always_comb begin
    elig = arrival_q;
    if (group_elig_q > elig) elig = group_elig_q;
    if (sched_elig_q > elig) elig = sched_elig_q;
    limit = arrival_q + max_res_q;
    pass  = (elig <= limit);
    // Past bucket_full the bucket overflowed; credit beyond full is forfeited.
    bucket_next = (elig < bucket_full_q) ? sched_elig_q
                                         : sched_elig_q + elig - bucket_full_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = CALC;
      CALC:    state_d = DECIDE;
      DECIDE:  state_d = OUTPUT;
      OUTPUT:  if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arrival_q       <= '0;
      frame_len_q     <= '0;
      time_per_byte_q <= '0;
      empty_to_full_q <= '0;
      max_res_q       <= '0;
      sched_elig_q    <= '0;
      bucket_full_q   <= '0;
      bucket_empty_q  <= '0;
      group_elig_q    <= '0;
      tdata_q         <= '0;
      tuser_q         <= 1'b0;
      tvalid_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_hs) begin
            arrival_q       <= s_axis_frame_info_tdata[TW-1:0];
            frame_len_q     <= s_axis_frame_info_tdata[TW +: FRAME_LEN_WIDTH];
            time_per_byte_q <= time_per_byte;
            empty_to_full_q <= empty_to_full_duration;
            max_res_q       <= max_residence_time;
          end
        end
        CALC: begin
          sched_elig_q  <= bucket_empty_q + length_recovery;
          bucket_full_q <= bucket_empty_q + empty_to_full_q;
        end
        DECIDE: begin
          if (pass) begin
            group_elig_q   <= elig;
            bucket_empty_q <= bucket_next;
          end
          tdata_q  <= elig;
          tuser_q  <= !pass;
          tvalid_q <= 1'b1;
        end
        OUTPUT: begin
          if (out_hs) tvalid_q <= 1'b0;
        end
        default: tvalid_q <= 1'b0;
      endcase
    end
  end

  assign m_axis_eligibility_timestamp_tdata  = tdata_q;
  assign m_axis_eligibility_timestamp_tuser  = tuser_q;
  assign m_axis_eligibility_timestamp_tvalid = tvalid_q;

`ifdef ATS_ELIGIBILITY_STATS_EN
  logic [31:0] pass_cnt_q;
  logic [31:0] discard_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pass_cnt_q    <= '0;
      discard_cnt_q <= '0;
    end else if (stats_clear) begin
      pass_cnt_q    <= '0;
      discard_cnt_q <= '0;
    end else if (out_hs) begin
      if (tuser_q) begin
        if (discard_cnt_q != '1) discard_cnt_q <= discard_cnt_q + 32'd1;
      end else begin
        if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + 32'd1;
      end
    end
  end

  assign pass_count    = pass_cnt_q;
  assign discard_count = discard_cnt_q;
`endif

endmodule
